// File: rtl/matrix_cmd_sequencer.sv
// matrix_cmd_sequencer
//   Command and data front end for the combinational matrix coprocessor.
//   The host writes 32-bit command words. These words load the A and B
//   operands byte by byte, launch an EXEC, or stream the captured 200-bit
//   result back as seven 32-bit words.
//
//   Optional build macro: SEQ_WATCHDOG_EN. When it is defined, a WAIT that
//   lasts TIMEOUT_CYCLES cycles without process_Done aborts the EXEC. The
//   abort sets err_flag and zeroes the captured result.
//
// Ports
//   clk, reset        system clock, async active-high reset
//   cmd_data/valid    host command word and its valid; cmd_ready = IDLE
//   op_code, matrix_size, matrix_a, matrix_b, scalar
//                     registered operands driven to the coprocessor
//   process_Done, result_final, overflow
//                     coprocessor completion, result and overflow
//   res_data/valid/ready/last
//                     result stream; res_last marks word 6
//   busy              state != IDLE
//   ovf_flag          overflow captured by the last EXEC
//   err_flag          sticky illegal-command / timeout flag
//   exec_done         one-cycle pulse when a result is captured
module matrix_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  cmd_data,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    output logic [2:0]   op_code,
    output logic [1:0]   matrix_size,
    output logic [199:0] matrix_a,
    output logic [199:0] matrix_b,
    output logic [7:0]   scalar,
    input  logic         process_Done,
    input  logic [199:0] result_final,
    input  logic         overflow,
    output logic [31:0]  res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_last,
    output logic         busy,
    output logic         ovf_flag,
    output logic         err_flag,
    output logic         exec_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam logic [2:0] OP_IDLE = 3'b111;

    // Catch a nonsensical timeout at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t         state;
    logic [199:0]   result_q;
    logic [2:0]     word_idx;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    // Writes up to three bytes starting at element k. Bytes that would land
    // past element 24 are dropped.
    function automatic logic [199:0] load_bytes(input logic [199:0] cur,
                                                input logic [31:0]  cmd);
        logic [199:0] v;
        logic [5:0]   idx;
        v = cur;
        for (int j = 0; j < 3; j++) begin
            idx = {1'b0, cmd[7:3]} + 6'(j);
            if (idx <= 6'd24)
                v[8*idx +: 8] = cmd[8*(j+1) +: 8];
        end
        return v;
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_STREAM);
    assign res_last  = res_valid && (word_idx == 3'd6);

    always_comb begin
        res_data = 32'h0;
        case (word_idx)
            3'd0:    res_data = result_q[31:0];
            3'd1:    res_data = result_q[63:32];
            3'd2:    res_data = result_q[95:64];
            3'd3:    res_data = result_q[127:96];
            3'd4:    res_data = result_q[159:128];
            3'd5:    res_data = result_q[191:160];
            default: res_data = {24'h0, result_q[199:192]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            matrix_a    <= '0;
            matrix_b    <= '0;
            result_q    <= '0;
            scalar      <= '0;
            matrix_size <= '0;
            op_code     <= OP_IDLE;
            word_idx    <= '0;
            ovf_flag    <= 1'b0;
            err_flag    <= 1'b0;
            exec_done   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt      <= '0;
`endif
        end else begin
            exec_done <= 1'b0;
            case (state)
                // cmd_ready is high in IDLE, so cmd_valid alone means a transfer.
                S_IDLE: if (cmd_valid) begin
                    case (cmd_data[2:0])
                        3'b000: matrix_a <= load_bytes(matrix_a, cmd_data);
                        3'b001: matrix_b <= load_bytes(matrix_b, cmd_data);
                        3'b010: begin
                            // The coprocessor treats op 111 as idle, so an
                            // EXEC that requests it is rejected.
                            if (cmd_data[5:3] == OP_IDLE) begin
                                err_flag <= 1'b1;
                            end else begin
                                op_code     <= cmd_data[5:3];
                                matrix_size <= cmd_data[7:6];
                                scalar      <= cmd_data[15:8];
                                ovf_flag    <= 1'b0;
                                state       <= S_SETTLE;
                            end
                        end
                        3'b011: begin
                            word_idx <= '0;
                            state    <= S_STREAM;
                        end
                        default: err_flag <= 1'b1;
                    endcase
                end
                S_SETTLE: begin
                    state <= S_WAIT;
`ifdef SEQ_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (process_Done) begin
                        result_q  <= result_final;
                        ovf_flag  <= overflow;
                        exec_done <= 1'b1;
                        op_code   <= OP_IDLE;
                        state     <= S_IDLE;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        err_flag <= 1'b1;
                        result_q <= '0;
                        op_code  <= OP_IDLE;
                        state    <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_STREAM: if (res_ready) begin
                    if (word_idx == 3'd6)
                        state <= S_IDLE;
                    else
                        word_idx <= word_idx + 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_cmd_sequencer.sv
module tb_matrix_cmd_sequencer;

    localparam int TO = 8;
    localparam int M_IDLE = 0, M_SETTLE = 1, M_WAIT = 2, M_STREAM = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cmd_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   op_code;
    logic [1:0]   matrix_size;
    logic [199:0] matrix_a, matrix_b;
    logic [7:0]   scalar;
    logic         process_Done;
    logic [199:0] result_final;
    logic         overflow;
    logic [31:0]  res_data;
    logic         res_valid, res_ready, res_last;
    logic         busy, ovf_flag, err_flag, exec_done;

    always #5 clk = ~clk;

    matrix_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .op_code(op_code), .matrix_size(matrix_size),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .scalar(scalar),
        .process_Done(process_Done), .result_final(result_final), .overflow(overflow),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
        .busy(busy), .ovf_flag(ovf_flag), .err_flag(err_flag), .exec_done(exec_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (element arrays + mode) ----------------
    logic [7:0] m_a [25];
    logic [7:0] m_b [25];
    logic [7:0] m_r [25];
    int         m_mode = M_IDLE;
    int         m_word = 0;
    int         m_wait = 0;
    logic [2:0] m_op = 3'b111;
    logic [1:0] m_size = 2'b00;
    logic [7:0] m_scalar = 8'h00;
    logic       m_ovf = 1'b0, m_err = 1'b0, m_done = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 25; i++) begin
            m_a[i] = 8'h00; m_b[i] = 8'h00; m_r[i] = 8'h00;
        end
        m_mode = M_IDLE; m_word = 0; m_wait = 0;
        m_op = 3'b111; m_size = 2'b00; m_scalar = 8'h00;
        m_ovf = 1'b0; m_err = 1'b0; m_done = 1'b0;
    endtask

    initial model_reset();

    function automatic logic [199:0] pack_a();
        logic [199:0] v;
        for (int i = 0; i < 25; i++) v[8*i +: 8] = m_a[i];
        return v;
    endfunction

    function automatic logic [199:0] pack_b();
        logic [199:0] v;
        for (int i = 0; i < 25; i++) v[8*i +: 8] = m_b[i];
        return v;
    endfunction

    function automatic logic [31:0] word_of(input int w);
        logic [31:0] v;
        v = 32'h0;
        for (int j = 0; j < 4; j++)
            if (4*w + j < 25) v[8*j +: 8] = m_r[4*w + j];
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            case (m_mode)
                M_IDLE: if (cmd_valid) begin
                    case (cmd_data[2:0])
                        3'd0, 3'd1: begin
                            for (int j = 0; j < 3; j++) begin
                                int e;
                                e = int'(cmd_data[7:3]) + j;
                                if (e <= 24) begin
                                    if (cmd_data[0]) m_b[e] = cmd_data[8*(j+1) +: 8];
                                    else             m_a[e] = cmd_data[8*(j+1) +: 8];
                                end
                            end
                        end
                        3'd2: begin
                            if (cmd_data[5:3] == 3'b111) m_err = 1'b1;
                            else begin
                                m_op = cmd_data[5:3];
                                m_size = cmd_data[7:6];
                                m_scalar = cmd_data[15:8];
                                m_ovf = 1'b0;
                                m_mode = M_SETTLE;
                            end
                        end
                        3'd3: begin m_mode = M_STREAM; m_word = 0; end
                        default: m_err = 1'b1;
                    endcase
                end
                M_SETTLE: begin m_mode = M_WAIT; m_wait = 0; end
                M_WAIT: begin
                    if (process_Done) begin
                        for (int i = 0; i < 25; i++) m_r[i] = result_final[8*i +: 8];
                        m_ovf = overflow;
                        m_done = 1'b1;
                        m_mode = M_IDLE;
                        m_op = 3'b111;
                    end else begin
                        m_wait++;
`ifdef SEQ_WATCHDOG_EN
                        if (m_wait == TO) begin
                            m_err = 1'b1;
                            for (int i = 0; i < 25; i++) m_r[i] = 8'h00;
                            m_mode = M_IDLE;
                            m_op = 3'b111;
                        end
`endif
                    end
                end
                default: if (res_ready) begin
                    if (m_word == 6) m_mode = M_IDLE;
                    else m_word++;
                end
            endcase
            if (m_mode == M_IDLE) m_op = 3'b111;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", busy, m_mode != M_IDLE);
        chk("cmd_ready", cmd_ready, m_mode == M_IDLE);
        chk("op_code", op_code, m_op);
        chk("matrix_size", matrix_size, m_size);
        chk("scalar", scalar, m_scalar);
        chk("matrix_a", matrix_a, pack_a());
        chk("matrix_b", matrix_b, pack_b());
        chk("ovf_flag", ovf_flag, m_ovf);
        chk("err_flag", err_flag, m_err);
        chk("exec_done", exec_done, m_done);
        chk("res_valid", res_valid, m_mode == M_STREAM);
        chk("res_last", res_last, (m_mode == M_STREAM) && (m_word == 6));
        if (m_mode == M_STREAM) chk("res_data", res_data, word_of(m_word));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] c);
        cmd_data = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [199:0] exp_a;
    logic [31:0]  wd [7];
    logic         wl [7];
    logic [31:0]  pd;
    logic         pl, prev_stall;
    int           nw, busy_cnt, dn_cnt, dn_seen;

    initial begin
        reset = 1'b1; cmd_data = '0; cmd_valid = 1'b0; process_Done = 1'b0;
        result_final = '0; overflow = 1'b0; res_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_op_code", op_code, 3'b111);
        chk("rst_matrix_a", matrix_a, 200'h0);
        chk("rst_err", err_flag, 1'b0);

        // Operand packing, including the drop past element 24.
        send(32'h03020100);
        send(32'hBBAA7FC0);
        exp_a = (200'h7F << 192) | 200'h030201;
        chk("load_a_pack", matrix_a, exp_a);
        chk("load_a_err", err_flag, 1'b0);

        // 2x2 of 10h in A and B, then EXEC with Done tied high.
        send(32'h00101000); send(32'h00101028);
        send(32'h00101001); send(32'h00101029);
        process_Done = 1'b1; overflow = 1'b1; result_final = {25{8'h20}};
        send(32'h00000502);
        chk("exec_opcode_settle", op_code, 3'b000);
        chk("exec_busy_settle", busy, 1'b1);
        tick();
        chk("exec_done_early", exec_done, 1'b0);
        tick();
        chk("exec_done_edge2", exec_done, 1'b1);
        chk("exec_ovf", ovf_flag, 1'b1);
        process_Done = 1'b0; overflow = 1'b0;

        // EXEC op 100, Done low for 5 WAIT cycles.
        result_final = 200'h1;
        send(32'h00008062);
        busy_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            if (exec_done) dn_cnt++;
            if (i == 6) process_Done = 1'b1;
            if (i == 7) begin process_Done = 1'b0; result_final = '1; end
            tick();
        end
        chk("stall_busy_cycles", busy_cnt, 7);
        chk("stall_exec_done_count", dn_cnt, 1);

        // Stream the captured result with res_ready toggling.
        send(32'h00000003);
        nw = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 40 && nw < 7; c++) begin
            if (res_valid) begin
                if (prev_stall) begin
                    chk("stream_hold_data", res_data, pd);
                    chk("stream_hold_last", res_last, pl);
                end
                pd = res_data; pl = res_last;
                res_ready = c[0];
                prev_stall = !res_ready;
                if (res_ready) begin wd[nw] = res_data; wl[nw] = res_last; nw++; end
            end
            tick();
        end
        res_ready = 1'b0;
        chk("stream_word_count", nw, 7);
        for (int i = 0; i < 7; i++) begin
            chk("stream_word", wd[i], (i == 0) ? 32'h1 : 32'h0);
            chk("stream_last", wl[i], i == 6);
        end
        chk("stream_back_idle", busy, 1'b0);

        // Illegal command and illegal EXEC op.
        chk("pre_err", err_flag, 1'b0);
        send(32'h00000005);
        chk("illegal_cmd_err", err_flag, 1'b1);
        chk("illegal_cmd_idle", busy, 1'b0);
        send(32'h0000003A);
        chk("illegal_op_idle", busy, 1'b0);
        chk("illegal_op_opcode", op_code, 3'b111);

        // Reset in WAIT.
        send(32'h0000000A);
        tick(); tick();
        chk("wait_busy", busy, 1'b1);
        reset = 1'b1; #1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_op", op_code, 3'b111);
        chk("rstw_a", matrix_a, 200'h0);
        chk("rstw_b", matrix_b, 200'h0);
        chk("rstw_err", err_flag, 1'b0);
        chk("rstw_scalar", scalar, 8'h0);
        tick(); reset = 1'b0; tick();

        // Reset in STREAM word 3.
        send(32'h00000003);
        res_ready = 1'b1;
        repeat (3) tick();
        res_ready = 1'b0;
        chk("str3_valid", res_valid, 1'b1);
        reset = 1'b1; #1;
        chk("rsts_valid", res_valid, 1'b0);
        chk("rsts_last", res_last, 1'b0);
        chk("rsts_busy", busy, 1'b0);
        tick(); reset = 1'b0; tick();

`ifdef SEQ_WATCHDOG_EN
        // Capture a nonzero result, then let an EXEC time out.
        process_Done = 1'b1; result_final = '1;
        send(32'h00000002);
        tick(); tick();
        process_Done = 1'b0;
        send(32'h00000012);
        tick();
        dn_seen = 0;
        for (int i = 0; i < TO; i++) begin
            chk("wd_err_early", err_flag, 1'b0);
            chk("wd_busy", busy, 1'b1);
            tick();
            if (exec_done) dn_seen++;
        end
        chk("wd_err", err_flag, 1'b1);
        chk("wd_idle", busy, 1'b0);
        chk("wd_no_done", dn_seen, 0);
        send(32'h00000003);
        chk("wd_result_zero", res_data, 32'h0);
        res_ready = 1'b1;
        repeat (7) tick();
        res_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end
            r = $urandom_range(0, 15);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_data = $urandom;
            if (r < 5)       cmd_data[2:0] = 3'd0;
            else if (r < 9)  cmd_data[2:0] = 3'd1;
            else if (r < 13) cmd_data[2:0] = 3'd2;
            else if (r < 15) cmd_data[2:0] = 3'd3;
            else             cmd_data[2:0] = 3'(4 + $urandom_range(0, 3));
            process_Done = ($urandom_range(0, 3) == 0);
            overflow = 1'($urandom_range(0, 1));
            for (int j = 0; j < 25; j++) result_final[8*j +: 8] = 8'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
